hilo_muldiv_unit: RTL and testbench

- Parametrised multi-cycle multiply/divide unit with HI/LO registers for the MIPS datapath.
- Decodes Op/funct for the R-type HI/LO class (mult, multu, div, divu, mfhi, mflo, mthi, mtlo) and runs iterative shift-add multiply and restoring divide over WIDTH cycles.
- Sits beside the main ALU in EX; the pipeline stalls on Busy and takes mfhi/mflo data from Result on Done.

---
 rtl/hilo_muldiv_unit_if.sv | 27 ++
 rtl/hilo_muldiv_unit.sv | 172 +++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hilo_muldiv_unit_if.sv
// Request/response bundle for the HI/LO multiply/divide unit.
// Ports: Start/Op/Funct/A/B request from the pipeline; Busy/Done/Result/
// Hi/Lo/DivZero/Illegal returned by the unit. master = EX stage, slave = unit.
interface hilo_muldiv_unit_if #(parameter int WIDTH = 32);
  logic             Start;
  logic [5:0]       Op;
  logic [5:0]       Funct;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Result;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic             DivZero;
  logic             Illegal;

  modport master (
    output Start, Op, Funct, A, B,
    input  Busy, Done, Result, Hi, Lo, DivZero, Illegal
  );

  modport slave (
    input  Start, Op, Funct, A, B,
    output Busy, Done, Result, Hi, Lo, DivZero, Illegal
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// Purpose: MIPS HI/LO unit - iterative mult/multu/div/divu plus mfhi/mflo/mthi/mtlo.
// Latency: iterative ops WIDTH+1 cycles (Done at the HI/LO write edge); moves Done next cycle.
// Backpressure: Busy=1 during RUN/FIX; Start is ignored while Busy, no queueing.
// Ports: Clk, Reset (async, active-high); bus = slave side of hilo_muldiv_unit_if.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Reset,
  hilo_muldiv_unit_if.slave     bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, acc_nxt;   // mult: {partial hi, multiplier}; div: {remainder, dividend/quotient}
  logic [WIDTH-1:0]   opnd;           // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   a_orig;         // unmodified dividend for the divide-by-zero result
  logic [WIDTH-1:0]   hi_q, lo_q, res_q;
  logic               op_div, res_neg, rem_neg, div_zero;
  logic               done_q, dz_q, ill_q;

  logic               legal, is_iter, is_signed, accept;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_rs, div_diff, rem_sel;
  logic               div_borrow;
  logic               unused_rem_msb;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // ---------------- request decode ----------------
  always_comb begin
    legal = 1'b0;
    if (bus.Op == 6'd0) begin
      case (bus.Funct)
        F_MFHI, F_MTHI, F_MFLO, F_MTLO,
        F_MULT, F_MULTU, F_DIV, F_DIVU: legal = 1'b1;
        default:                        legal = 1'b0;
      endcase
    end
  end

  assign is_iter   = legal && (bus.Funct[5:2] == 4'b0110);
  assign is_signed = ~bus.Funct[0];   // mult/div are even codes, the unsigned forms odd
  assign accept    = bus.Start && (state == IDLE);
  assign mag_a     = (is_signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
  assign mag_b     = (is_signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;

  // ---------------- FSM ----------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && is_iter) state_nxt = RUN;
      RUN:     if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- iteration step ----------------
  always_comb begin
    // Shift-add: conditionally add into the upper half, then shift the whole accumulator right.
    mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    // Restoring divide: bring in the next dividend bit and trial-subtract the divisor.
    div_rs     = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_borrow = div_rs < {1'b0, opnd};
    div_diff   = div_rs - {1'b0, opnd};
    rem_sel    = div_borrow ? div_rs : div_diff;
    acc_nxt    = op_div ? {rem_sel[WIDTH-1:0], acc[WIDTH-2:0], ~div_borrow}
                        : {mul_sum, acc[WIDTH-1:1]};
  end

  // The kept remainder is always below the divisor, so its top bit is always zero.
  assign unused_rem_msb = rem_sel[WIDTH];

  assign prod_fix = res_neg ? -acc : acc;
  assign quo_fix  = res_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = rem_neg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  // ---------------- datapath / architectural registers ----------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      a_orig   <= '0;
      op_div   <= 1'b0;
      res_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      div_zero <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_q    <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      ill_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      ill_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (!legal) begin
              done_q <= 1'b1;
              ill_q  <= 1'b1;
            end else if (is_iter) begin
              op_div   <= bus.Funct[1];
              cnt      <= '0;
              acc      <= {{WIDTH{1'b0}}, (bus.Funct[1] ? mag_a : mag_b)};
              opnd     <= bus.Funct[1] ? mag_b : mag_a;
              a_orig   <= bus.A;
              res_neg  <= is_signed && (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
              rem_neg  <= is_signed && bus.A[WIDTH-1];
              div_zero <= bus.Funct[1] && (bus.B == '0);
            end else begin
              done_q <= 1'b1;
              case (bus.Funct)
                F_MFHI:  res_q <= hi_q;
                F_MFLO:  res_q <= lo_q;
                F_MTHI:  hi_q  <= bus.A;
                default: lo_q  <= bus.A;   // mtlo, the only remaining legal move
              endcase
            end
          end
        end
        RUN: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          done_q <= 1'b1;
          dz_q   <= div_zero;
          if (!op_div) begin
            {hi_q, lo_q} <= prod_fix;
          end else if (div_zero) begin
            lo_q <= '1;
            hi_q <= a_orig;
          end else begin
            lo_q <= quo_fix;
            hi_q <= rem_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Busy    = (state != IDLE);
  assign bus.Done    = done_q;
  assign bus.Result  = res_q;
  assign bus.Hi      = hi_q;
  assign bus.Lo      = lo_q;
  assign bus.DivZero = dz_q;
  assign bus.Illegal = ill_q;
endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit at WIDTH=32: scoreboard of expected HI/LO/Result
// values pushed at issue time from a behavioural model, popped on Done.
module tb_hilo_muldiv_unit;
  logic Clk;
  logic Reset;

  hilo_muldiv_unit_if #(.WIDTH(32)) bus();

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] res;
    logic        dz;
    logic        ill;
  } exp_t;

  exp_t        scb[$];
  logic [31:0] m_hi, m_lo, m_res;
  int          passed;
  int          total;

  // Behavioural reference: updates the model registers and queues the expected outcome.
  task automatic push_exp(input logic [5:0] op, input logic [5:0] funct,
                          input logic [31:0] a, input logic [31:0] b);
    exp_t               e;
    logic signed [31:0] sa, sbv;
    logic signed [63:0] pa, pb, pp;
    logic [63:0]        up;
    e.dz  = 1'b0;
    e.ill = 1'b0;
    if (op != 6'd0 || !(funct inside {6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B})) begin
      e.ill = 1'b1;
    end else begin
      case (funct)
        6'h10: m_res = m_hi;
        6'h11: m_hi  = a;
        6'h12: m_res = m_lo;
        6'h13: m_lo  = a;
        6'h18: begin
          sa = a; sbv = b; pa = sa; pb = sbv; pp = pa * pb;
          {m_hi, m_lo} = pp;
        end
        6'h19: begin
          up = {32'd0, a} * {32'd0, b};
          {m_hi, m_lo} = up;
        end
        6'h1A: begin
          if (b == 32'd0) begin
            e.dz = 1'b1; m_lo = 32'hFFFF_FFFF; m_hi = a;
          end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            m_lo = 32'h8000_0000; m_hi = 32'd0;
          end else begin
            sa = a; sbv = b;
            m_lo = sa / sbv;
            m_hi = sa % sbv;
          end
        end
        default: begin
          if (b == 32'd0) begin
            e.dz = 1'b1; m_lo = 32'hFFFF_FFFF; m_hi = a;
          end else begin
            m_lo = a / b;
            m_hi = a % b;
          end
        end
      endcase
    end
    e.hi  = m_hi;
    e.lo  = m_lo;
    e.res = m_res;
    scb.push_back(e);
  endtask

  // Presents one Start cycle and records the expectation; returns on the negedge after acceptance.
  task automatic issue(input logic [5:0] op, input logic [5:0] funct,
                       input logic [31:0] a, input logic [31:0] b);
    @(negedge Clk);
    bus.Start = 1'b1; bus.Op = op; bus.Funct = funct; bus.A = a; bus.B = b;
    push_exp(op, funct, a, b);
    @(negedge Clk);
    bus.Start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    int n = 0;
    while (!bus.Done && n < 200) begin
      @(negedge Clk);
      n++;
    end
    ok = bus.Done;
  endtask

  task automatic test_reset;
    bit seen;
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    total++; if (bus.Busy !== 1'b0)     $display("FAIL reset_busy: got %b expected 0", bus.Busy);       else passed++;
    total++; if (bus.Done !== 1'b0)     $display("FAIL reset_done: got %b expected 0", bus.Done);       else passed++;
    total++; if (bus.Hi !== 32'd0)      $display("FAIL reset_hi: got %h expected 0", bus.Hi);           else passed++;
    total++; if (bus.Lo !== 32'd0)      $display("FAIL reset_lo: got %h expected 0", bus.Lo);           else passed++;
    total++; if (bus.Result !== 32'd0)  $display("FAIL reset_result: got %h expected 0", bus.Result);   else passed++;
    total++; if (bus.DivZero !== 1'b0)  $display("FAIL reset_divzero: got %b expected 0", bus.DivZero); else passed++;
    total++; if (bus.Illegal !== 1'b0)  $display("FAIL reset_illegal: got %b expected 0", bus.Illegal); else passed++;
    Reset = 1'b0;
    // Load Hi/Lo so the mid-operation reset has something to clear.
    issue(6'd0, 6'h11, 32'h0000_AAAA, 32'd0);
    issue(6'd0, 6'h13, 32'h0000_5555, 32'd0);
    scb.delete();
    total++; if (bus.Hi !== 32'h0000_AAAA) $display("FAIL pre_reset_hi: got %h expected 0000aaaa", bus.Hi); else passed++;
    issue(6'd0, 6'h19, 32'h1234_5678, 32'h9ABC_DEF0);
    scb.delete();
    repeat (10) @(negedge Clk);
    Reset = 1'b1;
    #1;
    total++; if (bus.Busy !== 1'b0)    $display("FAIL midrun_busy: got %b expected 0", bus.Busy);     else passed++;
    total++; if (bus.Hi !== 32'd0)     $display("FAIL midrun_hi: got %h expected 0", bus.Hi);         else passed++;
    total++; if (bus.Lo !== 32'd0)     $display("FAIL midrun_lo: got %h expected 0", bus.Lo);         else passed++;
    total++; if (bus.Result !== 32'd0) $display("FAIL midrun_result: got %h expected 0", bus.Result); else passed++;
    @(negedge Clk);
    Reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0; m_res = 32'd0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (bus.Done) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) $display("FAIL reset_no_done: got %b expected 0", seen); else passed++;
  endtask

  task automatic test_mult;
    logic [31:0] av[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD};
    logic [31:0] bv[2] = '{32'hFFFF_FFFF, 32'h0000_0005};
    logic [5:0]  fv[2] = '{6'h19, 6'h18};
    for (int k = 0; k < 2; k++) begin
      int   nbusy;
      exp_t e;
      issue(6'd0, fv[k], av[k], bv[k]);
      nbusy = 0;
      while (bus.Busy && nbusy < 100) begin
        nbusy++;
        @(negedge Clk);
      end
      total++; if (nbusy !== 33)     $display("FAIL mult%0d_busy_cycles: got %0d expected 33", k, nbusy); else passed++;
      total++; if (bus.Done !== 1'b1) $display("FAIL mult%0d_done: got %b expected 1", k, bus.Done); else passed++;
      e = scb.pop_front();
      total++; if (bus.Hi !== e.hi)   $display("FAIL mult%0d_hi: got %h expected %h", k, bus.Hi, e.hi); else passed++;
      total++; if (bus.Lo !== e.lo)   $display("FAIL mult%0d_lo: got %h expected %h", k, bus.Lo, e.lo); else passed++;
      total++; if (bus.DivZero !== 1'b0) $display("FAIL mult%0d_divzero: got %b expected 0", k, bus.DivZero); else passed++;
      @(negedge Clk);
      total++; if (bus.Done !== 1'b0) $display("FAIL mult%0d_done_pulse: got %b expected 0", k, bus.Done); else passed++;
    end
  endtask

  task automatic test_div;
    logic [31:0] av[3] = '{32'hFFFF_FFF9, 32'h0000_0007, 32'h8000_0000};
    logic [31:0] bv[3] = '{32'h0000_0002, 32'h0000_0000, 32'hFFFF_FFFF};
    logic [5:0]  fv[3] = '{6'h1A, 6'h1B, 6'h1A};
    for (int k = 0; k < 7; k++) begin
      bit          ok;
      exp_t        e;
      logic [31:0] a, b;
      logic [5:0]  f;
      if (k < 3) begin
        a = av[k]; b = bv[k]; f = fv[k];
      end else begin
        a = $urandom; b = (k == 6) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
        f = 6'h18 + 6'($urandom_range(0, 3));
      end
      issue(6'd0, f, a, b);
      wait_done(ok);
      total++; if (!ok) $display("FAIL div%0d_timeout: got no Done expected Done", k); else passed++;
      e = scb.pop_front();
      total++; if (bus.Lo !== e.lo)      $display("FAIL div%0d_lo: got %h expected %h (f=%h a=%h b=%h)", k, bus.Lo, e.lo, f, a, b); else passed++;
      total++; if (bus.Hi !== e.hi)      $display("FAIL div%0d_hi: got %h expected %h (f=%h a=%h b=%h)", k, bus.Hi, e.hi, f, a, b); else passed++;
      total++; if (bus.DivZero !== e.dz) $display("FAIL div%0d_divzero: got %b expected %b", k, bus.DivZero, e.dz); else passed++;
    end
  endtask

  task automatic test_single;
    logic [5:0]  fv[4] = '{6'h11, 6'h13, 6'h10, 6'h12};
    logic [31:0] av[4] = '{32'h0000_1234, 32'h0000_5678, 32'd0, 32'd0};
    @(negedge Clk);
    for (int k = 0; k <= 4; k++) begin
      if (k > 0) begin
        exp_t e;
        e = scb.pop_front();
        total++; if (bus.Done !== 1'b1)   $display("FAIL single%0d_done: got %b expected 1", k, bus.Done); else passed++;
        total++; if (bus.Busy !== 1'b0)   $display("FAIL single%0d_busy: got %b expected 0", k, bus.Busy); else passed++;
        total++; if (bus.Result !== e.res) $display("FAIL single%0d_result: got %h expected %h", k, bus.Result, e.res); else passed++;
        total++; if (bus.Hi !== e.hi)     $display("FAIL single%0d_hi: got %h expected %h", k, bus.Hi, e.hi); else passed++;
        total++; if (bus.Lo !== e.lo)     $display("FAIL single%0d_lo: got %h expected %h", k, bus.Lo, e.lo); else passed++;
      end
      if (k < 4) begin
        bus.Start = 1'b1; bus.Op = 6'd0; bus.Funct = fv[k]; bus.A = av[k]; bus.B = 32'd0;
        push_exp(6'd0, fv[k], av[k], 32'd0);
        @(negedge Clk);
      end else begin
        bus.Start = 1'b0;
      end
    end
  endtask

  task automatic test_interlock;
    bit   ok;
    exp_t e;
    issue(6'd0, 6'h19, 32'h0001_2345, 32'h0000_0100);
    @(negedge Clk);
    bus.Start = 1'b1; bus.Funct = 6'h11; bus.A = 32'h0000_DEAD;
    @(negedge Clk);
    bus.Start = 1'b0;
    wait_done(ok);
    total++; if (!ok) $display("FAIL interlock_timeout: got no Done expected Done"); else passed++;
    e = scb.pop_front();
    total++; if (bus.Hi !== e.hi) $display("FAIL interlock_hi: got %h expected %h", bus.Hi, e.hi); else passed++;
    total++; if (bus.Lo !== e.lo) $display("FAIL interlock_lo: got %h expected %h", bus.Lo, e.lo); else passed++;
    // Start held on the Done cycle must be accepted.
    bus.Start = 1'b1; bus.Op = 6'd0; bus.Funct = 6'h12; bus.A = 32'd0;
    push_exp(6'd0, 6'h12, 32'd0, 32'd0);
    @(negedge Clk);
    bus.Start = 1'b0;
    e = scb.pop_front();
    total++; if (bus.Done !== 1'b1)    $display("FAIL b2b_done: got %b expected 1", bus.Done); else passed++;
    total++; if (bus.Result !== e.res) $display("FAIL b2b_result: got %h expected %h", bus.Result, e.res); else passed++;
  endtask

  task automatic test_illegal;
    logic [5:0] ov[2] = '{6'h1C, 6'h00};
    logic [5:0] fv[2] = '{6'h10, 6'h20};
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      issue(ov[k], fv[k], 32'hCAFE_F00D, 32'h1111_2222);
      e = scb.pop_front();
      total++; if (bus.Done !== 1'b1)     $display("FAIL illegal%0d_done: got %b expected 1", k, bus.Done); else passed++;
      total++; if (bus.Illegal !== e.ill) $display("FAIL illegal%0d_flag: got %b expected %b", k, bus.Illegal, e.ill); else passed++;
      total++; if (bus.Hi !== e.hi)       $display("FAIL illegal%0d_hi: got %h expected %h", k, bus.Hi, e.hi); else passed++;
      total++; if (bus.Lo !== e.lo)       $display("FAIL illegal%0d_lo: got %h expected %h", k, bus.Lo, e.lo); else passed++;
      total++; if (bus.Result !== e.res)  $display("FAIL illegal%0d_result: got %h expected %h", k, bus.Result, e.res); else passed++;
      total++; if (bus.Busy !== 1'b0)     $display("FAIL illegal%0d_busy: got %b expected 0", k, bus.Busy); else passed++;
      @(negedge Clk);
      total++; if (bus.Illegal !== 1'b0)  $display("FAIL illegal%0d_clear: got %b expected 0", k, bus.Illegal); else passed++;
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    m_hi = 32'd0; m_lo = 32'd0; m_res = 32'd0;
    bus.Start = 1'b0; bus.Op = 6'd0; bus.Funct = 6'd0; bus.A = 32'd0; bus.B = 32'd0;
    test_reset();
    test_mult();
    test_div();
    test_single();
    test_interlock();
    test_illegal();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
